dsp_spi_link: RTL

- Downstream consumer of the RS485 receive stage: an SPI slave that gives the DSP coherent access to the decoded encoder frame (rx_data[63:0], time_interval[7:0]).
- The DSP issues commands over SPI to trigger a new encoder read (drives read_begin) or to shift out a snapshot of the latest frame plus checksum.
- Sits between the rs485_com outputs and the DSP pins; single clock domain clk_in (30 MHz), with SPI inputs synchronised internally.

---
 rtl/dsp_spi_link.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/dsp_spi_link.sv
// dsp_spi_link: SPI slave (mode 0, MSB first) that lets the DSP trigger an
// encoder read and shift out a coherent snapshot of the latest decoded frame.
//
// Ports:
//   clk_in         system clock (30 MHz)
//   sys_rst        synchronous active-high reset
//   rx_data        latest decoded encoder data (64 bits)
//   time_interval  interval value accompanying rx_data
//   read_begin     one-cycle pulse requesting a new encoder read
//   spi_cs_n       DSP chip select, active low, asynchronous
//   spi_sck        DSP SPI clock, asynchronous
//   spi_mosi       DSP -> FPGA serial data
//   spi_miso       FPGA -> DSP serial data
//   spi_miso_oe    pad enable for spi_miso, high while CS is active
//   frame_done     one-cycle pulse after the last data bit has been shifted
//   cmd_err_cnt    saturating count of unknown command bytes
module dsp_spi_link #(
    parameter logic [7:0]  CMD_READ_BEGIN = 8'h01,
    parameter logic [7:0]  CMD_READ_DATA  = 8'h02,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic        clk_in,
    input  logic        sys_rst,
    input  logic [63:0] rx_data,
    input  logic [7:0]  time_interval,
    output logic        read_begin,
    input  logic        spi_cs_n,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        frame_done,
    output logic [7:0]  cmd_err_cnt
);

    typedef enum logic [1:0] {StIdle, StCmd, StData, StIgnore} state_e;

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   cs_dly;
    logic                   sck_dly;

    logic cs_s, sck_s, mosi_s;
    logic rise_sck, fall_sck, fall_cs, rise_cs;

    state_e      state;
    logic [7:0]  cmd_sr;
    logic [7:0]  cmd_next;
    logic [79:0] shadow;
    logic [6:0]  bit_cnt;
    logic [7:0]  chk;

    // Input synchronisers plus one delay flop for edge detection.
    always_ff @(posedge clk_in) begin
        if (sys_rst) begin
            cs_sync   <= '1;
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_dly    <= 1'b1;
            sck_dly   <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            cs_dly    <= cs_sync[SYNC_STAGES-1];
            sck_dly   <= sck_sync[SYNC_STAGES-1];
        end
    end

    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // SCK edges only count while the synchronised select is active.
    assign rise_sck = ~cs_s & sck_s & ~sck_dly;
    assign fall_sck = ~cs_s & ~sck_s & sck_dly;
    assign fall_cs  = ~cs_s & cs_dly;
    assign rise_cs  = cs_s & ~cs_dly;

    assign cmd_next = {cmd_sr[6:0], mosi_s};

    always_comb begin
        chk = time_interval;
        for (int i = 0; i < 8; i++) begin
            chk = chk ^ rx_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk_in) begin
        if (sys_rst) begin
            state       <= StIdle;
            read_begin  <= 1'b0;
            frame_done  <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            cmd_err_cnt <= 8'd0;
            cmd_sr      <= 8'd0;
            shadow      <= 80'd0;
            bit_cnt     <= 7'd0;
        end else begin
            read_begin  <= 1'b0;
            frame_done  <= 1'b0;
            spi_miso_oe <= ~cs_s;
            // Deselect overrides everything, including a completing command byte.
            if (rise_cs) begin
                state    <= StIdle;
                spi_miso <= 1'b0;
                bit_cnt  <= 7'd0;
            end else begin
                case (state)
                    StIdle: begin
                        spi_miso <= 1'b0;
                        if (fall_cs) begin
                            state   <= StCmd;
                            bit_cnt <= 7'd0;
                        end
                    end
                    StCmd: begin
                        spi_miso <= 1'b0;
                        if (rise_sck) begin
                            cmd_sr  <= cmd_next;
                            bit_cnt <= bit_cnt + 7'd1;
                            if (bit_cnt == 7'd7) begin
                                if (cmd_next == CMD_READ_BEGIN) begin
                                    read_begin <= 1'b1;
                                    state      <= StIgnore;
                                end else if (cmd_next == CMD_READ_DATA) begin
                                    shadow  <= {rx_data, time_interval, chk};
                                    bit_cnt <= 7'd0;
                                    state   <= StData;
                                end else begin
                                    if (cmd_err_cnt != 8'hFF) begin
                                        cmd_err_cnt <= cmd_err_cnt + 8'd1;
                                    end
                                    state <= StIgnore;
                                end
                            end
                        end
                    end
                    StData: begin
                        if (fall_sck) begin
                            if (bit_cnt == 7'd80) begin
                                spi_miso   <= 1'b0;
                                frame_done <= 1'b1;
                                state      <= StIgnore;
                            end else begin
                                spi_miso <= shadow[79];
                                shadow   <= {shadow[78:0], 1'b0};
                                bit_cnt  <= bit_cnt + 7'd1;
                            end
                        end
                    end
                    StIgnore: begin
                        spi_miso <= 1'b0;
                    end
                    default: begin
                        state    <= StIdle;
                        spi_miso <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
